// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/logic/ENC plus iterative shift-add MUL
// and restoring DIV, behind a valid/ready request/response handshake.
module seq_alu #(
    parameter int               WIDTH = 8,
    parameter logic [2*WIDTH-1:0] KEY = 'hAB
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               overflow,
    output logic               div_by_zero,
    output logic               illegal_op,
    output logic               busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_ENC = 4'd8;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    typedef struct packed {
        logic [2*WIDTH-1:0] result;
        logic               carry;
        logic               overflow;
        logic               div_by_zero;
        logic               illegal_op;
    } rsp_t;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    req_t               req_q;
    rsp_t               rsp_q;
    rsp_t               imm_rsp;
    rsp_t               calc_rsp;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_addend;
    logic [2*WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem_nxt;
    logic [WIDTH-1:0]   div_quo_nxt;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_d;
    logic               multi_cycle;

    assign add_s       = {1'b0, a} + {1'b0, b};
    assign sub_d       = {1'b0, a} - {1'b0, b};
    assign multi_cycle = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

    // Single-cycle results, computed straight from the request operands.
    always_comb begin
        imm_rsp = '0;
        case (op)
            OP_ADD: begin
                imm_rsp.result[WIDTH-1:0] = add_s[WIDTH-1:0];
                imm_rsp.carry             = add_s[WIDTH];
                imm_rsp.overflow          = (a[WIDTH-1] == b[WIDTH-1]) &&
                                            (add_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                imm_rsp.result[WIDTH-1:0] = sub_d[WIDTH-1:0];
                imm_rsp.carry             = sub_d[WIDTH];
                imm_rsp.overflow          = (a[WIDTH-1] != b[WIDTH-1]) &&
                                            (sub_d[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: ;
            OP_DIV: begin
                imm_rsp.result      = {{WIDTH{1'b1}}, a};
                imm_rsp.div_by_zero = 1'b1;
            end
            OP_AND: imm_rsp.result[WIDTH-1:0] = a & b;
            OP_OR:  imm_rsp.result[WIDTH-1:0] = a | b;
            OP_XOR: imm_rsp.result[WIDTH-1:0] = a ^ b;
            OP_NOT: imm_rsp.result[WIDTH-1:0] = ~a;
            OP_ENC: imm_rsp.result            = {a, b} ^ KEY;
            default: imm_rsp.illegal_op       = 1'b1;
        endcase
    end

    // One multiplier bit per cycle, LSB first.
    assign mul_addend  = req_q.b[cnt] ? ({{WIDTH{1'b0}}, req_q.a} << cnt) : '0;
    assign mul_acc_nxt = mul_acc + mul_addend;

    // Restoring step: the partial remainder never exceeds 2*b-1, so the
    // difference's top bit is a clean borrow flag.
    assign div_sh      = {div_rem, div_quo[WIDTH-1]};
    assign div_diff    = div_sh - {1'b0, req_q.b};
    assign div_ge      = ~div_diff[WIDTH];
    assign div_rem_nxt = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_quo_nxt = {div_quo[WIDTH-2:0], div_ge};

    always_comb begin
        calc_rsp = '0;
        if (req_q.op == OP_MUL) begin
            calc_rsp.result   = mul_acc_nxt;
            calc_rsp.overflow = |mul_acc_nxt[2*WIDTH-1:WIDTH];
        end else begin
            calc_rsp.result   = {div_quo_nxt, div_rem_nxt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            rsp_q     <= '0;
            req_q     <= '0;
            cnt       <= '0;
            mul_acc   <= '0;
            div_rem   <= '0;
            div_quo   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        req_q    <= '{op: op, a: a, b: b};
                        cnt      <= '0;
                        mul_acc  <= '0;
                        div_rem  <= '0;
                        div_quo  <= a;
                        in_ready <= 1'b0;
                        if (multi_cycle) begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            rsp_q     <= imm_rsp;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (req_q.op == OP_MUL) begin
                        mul_acc <= mul_acc_nxt;
                    end else begin
                        div_rem <= div_rem_nxt;
                        div_quo <= div_quo_nxt;
                    end
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        rsp_q     <= calc_rsp;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign result      = rsp_q.result;
    assign carry       = rsp_q.carry;
    assign overflow    = rsp_q.overflow;
    assign div_by_zero = rsp_q.div_by_zero;
    assign illegal_op  = rsp_q.illegal_op;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes arithmetic-model expectations,
// a negedge monitor pops and checks results, flags, latency and hold behaviour.
module tb_seq_alu;
    localparam int W = 8;
    localparam int M = 1 << W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     op_i = '0;
    logic [W-1:0]   a_i = '0;
    logic [W-1:0]   b_i = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] result;
    logic           carry, overflow, div_by_zero, illegal_op, busy;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op_i), .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int op; int res; int c; int o; int z; int il; int lat; int acc;
    } exp_t;

    exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Reference behaviour in plain integer arithmetic.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int s;
        e = '{default: 0};
        e.op  = op;
        e.lat = 1;
        case (op)
            0: begin
                s = a + b;
                e.res = s % M;
                e.c = (s >= M);
                e.o = (sgn(a) + sgn(b) > M/2 - 1) || (sgn(a) + sgn(b) < -M/2);
            end
            1: begin
                e.res = (a - b + M) % M;
                e.c = (a < b);
                e.o = (sgn(a) - sgn(b) > M/2 - 1) || (sgn(a) - sgn(b) < -M/2);
            end
            2: begin
                e.res = a * b;
                e.o = (a * b >= M);
                e.lat = W + 1;
            end
            3: begin
                if (b == 0) begin
                    e.res = (M - 1) * M + a;
                    e.z = 1;
                end else begin
                    e.res = (a / b) * M + (a % b);
                    e.lat = W + 1;
                end
            end
            4: e.res = a & b;
            5: e.res = a | b;
            6: e.res = a ^ b;
            7: e.res = (M - 1) - a;
            8: e.res = (a * M + b) ^ 'hAB;
            default: e.il = 1;
        endcase
        return e;
    endfunction

    task automatic junk();
        in_valid = 1'b1;
        op_i = 4'($urandom);
        a_i  = W'($urandom);
        b_i  = W'($urandom);
    endtask

    // Called #1 after a rising edge with in_valid=0 and out_ready=0.
    task automatic do_op(input int op, input int a, input int b, input int hold);
        exp_t e;
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", int'(in_ready), 1);
            return;
        end
        in_valid = 1'b1;
        op_i = 4'(op);
        a_i  = W'(a);
        b_i  = W'(b);
        e = model(op, a, b);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        junk();
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk); #1; junk(); k++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", int'(out_valid), 1);
            in_valid = 1'b0;
            exp_q.delete();
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1; junk();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin : monitor
        exp_t cur;
        bit seen;
        int bcnt;
        seen = 0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
                bcnt = 0;
            end else begin
                if (busy) bcnt++;
                if (out_valid) begin
                    chk("in_ready_in_done", int'(in_ready), 0);
                    chk("busy_in_done", int'(busy), 0);
                    if (!seen) begin
                        chk("pending_count", exp_q.size(), 1);
                        if (exp_q.size() > 0) begin
                            cur = exp_q.pop_front();
                            chk($sformatf("op%0d result", cur.op), int'(result), cur.res);
                            chk($sformatf("op%0d carry", cur.op), int'(carry), cur.c);
                            chk($sformatf("op%0d overflow", cur.op), int'(overflow), cur.o);
                            chk($sformatf("op%0d div_by_zero", cur.op), int'(div_by_zero), cur.z);
                            chk($sformatf("op%0d illegal_op", cur.op), int'(illegal_op), cur.il);
                            chk($sformatf("op%0d latency", cur.op), cyc - cur.acc + 1, cur.lat);
                            chk($sformatf("op%0d busy_cycles", cur.op), bcnt, cur.lat - 1);
                        end
                        bcnt = 0;
                        seen = 1;
                    end else begin
                        chk("hold_result", int'(result), cur.res);
                        chk("hold_flags", int'({carry, overflow, div_by_zero, illegal_op}),
                            (cur.c << 3) | (cur.o << 2) | (cur.z << 1) | cur.il);
                    end
                end else begin
                    seen = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : driver
        int op, a, b;
        #1 rst_n = 1'b0;
        #1;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset result", int'(result), 0);
        chk("reset flags", int'({carry, overflow, div_by_zero, illegal_op}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", int'(in_ready), 1);

        do_op(0, 'h7F, 'h01, 0);
        do_op(1, 'h00, 'h01, 0);
        do_op(8, 'h00, 'h00, 0);
        do_op(2, 'hFF, 'hFF, 0);
        do_op(3, 100, 7, 0);
        do_op(3, 'h55, 0, 0);
        do_op(6, 'h3C, 'h0F, 5);
        do_op(7, 'hA5, 'h00, 1);
        do_op(4, 'hF0, 'h3C, 0);
        do_op(5, 'hF0, 'h0C, 0);
        do_op(12, 'h12, 'h34, 2);
        do_op(0, 'hFF, 'hFF, 0);
        do_op(1, 'h80, 'h01, 0);
        do_op(3, 'hFF, 'h01, 0);

        // Reset in the 4th CALC cycle of a MUL abandons it silently.
        while (!in_ready) begin @(posedge clk); #1; end
        in_valid = 1'b1; op_i = 4'd2; a_i = 8'hC3; b_i = 8'h5A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mul_busy_before_reset", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset out_valid", int'(out_valid), 0);
        chk("midreset result", int'(result), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset in_ready", int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(0, 'h03, 'h04, 0);

        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
            a  = int'($urandom_range(0, M - 1));
            b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, M - 1));
            do_op(op, a, b, int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (4 to 16).
REQ-002 SHALL have parameter KEY, default 'hAB (2*WIDTH bits, zero-extended), the ENC operation's XOR key.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port op, input, 4, opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 ENC, 9-15 illegal.
REQ-008 SHALL have port a, input, WIDTH, first operand.
REQ-009 SHALL have port b, input, WIDTH, second operand.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-012 SHALL have port result, output, 2*WIDTH, operation result.
REQ-013 SHALL have port carry, output, 1, ADD carry-out or SUB borrow.
REQ-014 SHALL have port overflow, output, 1, signed overflow (ADD/SUB) or product overflow (MUL).
REQ-015 SHALL have port div_by_zero, output, 1, DIV with b==0.
REQ-016 SHALL have port illegal_op, output, 1, opcode 9-15 accepted.
REQ-017 SHALL have port busy, output, 1, high while in CALC.

Function
REQ-018 SHALL run a three-state FSM: IDLE, CALC, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-019 SHALL accept a request on a rising edge with in_valid&in_ready, capturing op, a and b into registers; later changes to a, b or op SHALL have no effect.
REQ-020 SHALL, for ops 0,1,4-15 and for DIV with b==0, go IDLE->DONE on the accept edge (out_valid high in the next cycle).
REQ-021 SHALL, for MUL and DIV with b!=0, go IDLE->CALC on the accept edge, iterate one bit per cycle for exactly WIDTH cycles, then enter DONE (out_valid high WIDTH+1 cycles after accept).
REQ-022 SHALL hold result and all flags stable in DONE until out_ready=1, then return to IDLE on that edge; in_ready stays 0 throughout DONE.
REQ-023 SHALL ignore in_valid outside IDLE and out_ready outside DONE.
REQ-024 ADD: result = zero-extended (a+b) mod 2^WIDTH; carry = bit WIDTH of the sum; overflow = signed two's-complement overflow.
REQ-025 SUB: result = zero-extended (a-b) mod 2^WIDTH; carry = (a<b unsigned); overflow = signed overflow.
REQ-026 MUL: result = full 2*WIDTH unsigned product via shift-add; overflow = OR of product bits [2*WIDTH-1:WIDTH]; carry=0.
REQ-027 DIV: restoring unsigned division; result = {quotient, remainder}; b==0 gives quotient all ones, remainder = a, and div_by_zero=1.
REQ-028 AND/OR/XOR SHALL give the zero-extended bitwise result; NOT SHALL give zero-extended ~a; ENC SHALL give {a,b}^KEY.
REQ-029 Illegal opcodes SHALL give result=0 and illegal_op=1.
REQ-030 SHALL clear every flag not defined for the current op to 0; flags update together with result on entry to DONE.

Reset
REQ-031 SHALL, while rst_n=0, immediately force state IDLE, result=0, all flags 0, out_valid=0, busy=0 and in_ready=1 (in_ready, not a reset output, SHALL be 1 in the first cycle after reset).
REQ-032 SHALL abandon any operation in progress (CALC or DONE) on reset with no result delivered; the first request after release SHALL be processed normally.

Verification (WIDTH=8)
REQ-033 ADD a=0x7F b=0x01 -> one cycle after accept: result=0x0080, carry=0, overflow=1.
REQ-034 SUB a=0x00 b=0x01 -> result=0x00FF, carry=1, overflow=0; ENC a=0x00 b=0x00 -> result=0x00AB.
REQ-035 MUL a=0xFF b=0xFF -> busy high 8 cycles, out_valid 9 cycles after accept: result=0xFE01, overflow=1.
REQ-036 DIV a=100 b=7 -> result=0x0E02 after 9 cycles; DIV a=0x55 b=0 -> result=0xFF55, div_by_zero=1 after 1 cycle.
REQ-037 Hold out_ready=0 for 5 cycles in DONE while driving new in_valid and operands -> result/flags unchanged, in_ready=0, no request accepted.
REQ-038 Assert rst_n=0 at the 4th cycle of a MUL -> out_valid=0, result=0 at once; after release, ADD 0x03+0x04 -> result=0x0007.
